// File: rtl/sbox_sched_pkg.sv
// Shared constants for the S-box lane scheduler: state encoding, byte counts
// and requester identifiers.
package sbox_sched_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_A = 3'd1;
  localparam logic [2:0] S_BUSY_B = 3'd2;
  localparam logic [2:0] S_DONE_A = 3'd3;
  localparam logic [2:0] S_DONE_B = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_BUSY_A = S_BUSY_A,
    ST_BUSY_B = S_BUSY_B,
    ST_DONE_A = S_DONE_A,
    ST_DONE_B = S_DONE_B
  } state_e;

  localparam int NBYTES_STATE = 16;
  localparam int NBYTES_WORD  = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) (as x^254) followed by
// the affine transform. Purely combinational.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a, b;
    p = 8'h00;
    a = x;
    b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, base, e;
    r    = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv   = gf_inv(in_i);
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/sbox_sched_arb.sv
// Round-robin tie-break between the round datapath (A) and key schedule (B).
// Holds last_served; A wins the first tie after reset.
module sbox_sched_arb
  import sbox_sched_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_i,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic grant_o,
  output logic grant_id_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o    = sample_i && (a_req_i || b_req_i);
    grant_id_o = (a_req_i && (!b_req_i || last_q == REQ_B)) ? REQ_A : REQ_B;
    last_d     = grant_o ? grant_id_o : last_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= REQ_B;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/sbox_sched.sv
// Time-shares LANES S-box instances between SubBytes (A) and SubWord (B).
// Optional SBOX_SCHED_PERF_EN adds saturating grant/conflict counters.
module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic [127:0] a_data,
  output logic [127:0] a_result,
  output logic         a_done,
  input  logic         b_req,
  input  logic [31:0]  b_data,
  output logic [31:0]  b_result,
  output logic         b_done,
  output logic         busy
`ifdef SBOX_SCHED_PERF_EN
  ,
  output logic [15:0]  perf_grants_a,
  output logic [15:0]  perf_grants_b,
  output logic [15:0]  perf_conflicts
`endif
);

  localparam int NB_A = NBYTES_STATE / LANES;
  localparam int NB_B = NBYTES_WORD / LANES;
  localparam int BW   = (NB_A > 1) ? $clog2(NB_A) : 1;
  localparam logic [BW-1:0] LAST_A = BW'(NB_A - 1);
  localparam logic [BW-1:0] LAST_B = BW'(NB_B - 1);

  state_e         state_q;
  logic [BW-1:0]  beat_q;
  logic [127:0]   work_q;
  logic [127:0]   a_res_q, a_res_d;
  logic [31:0]    b_res_q, b_res_d;
  logic           a_done_q, b_done_q, busy_q;
  logic           grant, grant_id;
  logic [7:0]     lane_in  [LANES];
  logic [7:0]     lane_out [LANES];

  sbox_sched_arb u_arb (
    .clk_i      (clk),
    .rst_i      (rst),
    .sample_i   (state_q == ST_IDLE),
    .a_req_i    (a_req),
    .b_req_i    (b_req),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox u_sbox (.in_i(lane_in[g]), .out_o(lane_out[g]));
  end

  // B words sit in the top 32 bits of work_q, so byte i has the same offset for both jobs.
  always_comb begin
    int idx;
    for (int l = 0; l < LANES; l++) begin
      idx        = int'(beat_q) * LANES + l;
      lane_in[l] = 8'h00;
      if (state_q == ST_BUSY_A || state_q == ST_BUSY_B)
        lane_in[l] = work_q[127 - 8*idx -: 8];
    end
  end

  always_comb begin
    int idx;
    a_res_d = a_res_q;
    b_res_d = b_res_q;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(beat_q) * LANES + l;
      if (state_q == ST_BUSY_A) a_res_d[127 - 8*idx -: 8] = lane_out[l];
      if (state_q == ST_BUSY_B) b_res_d[31 - 8*idx -: 8]  = lane_out[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      work_q   <= '0;
      a_res_q  <= '0;
      b_res_q  <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            beat_q <= '0;
            busy_q <= 1'b1;
            if (grant_id == REQ_A) begin
              state_q <= ST_BUSY_A;
              work_q  <= a_data;
            end else begin
              state_q <= ST_BUSY_B;
              work_q  <= {b_data, 96'h0};
            end
          end
        end
        ST_BUSY_A: begin
          a_res_q <= a_res_d;
          if (beat_q == LAST_A) begin
            beat_q   <= '0;
            state_q  <= ST_DONE_A;
            a_done_q <= 1'b1;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        ST_BUSY_B: begin
          b_res_q <= b_res_d;
          if (beat_q == LAST_B) begin
            beat_q   <= '0;
            state_q  <= ST_DONE_B;
            b_done_q <= 1'b1;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        ST_DONE_A, ST_DONE_B: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_result = a_res_q;
  assign b_result = b_res_q;
  assign a_done   = a_done_q;
  assign b_done   = b_done_q;
  assign busy     = busy_q;

`ifdef SBOX_SCHED_PERF_EN
  logic [15:0] pga_q, pgb_q, pcf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pga_q <= '0;
      pgb_q <= '0;
      pcf_q <= '0;
    end else begin
      if (grant && grant_id == REQ_A && pga_q != 16'hFFFF) pga_q <= pga_q + 16'd1;
      if (grant && grant_id == REQ_B && pgb_q != 16'hFFFF) pgb_q <= pgb_q + 16'd1;
      if (state_q == ST_IDLE && a_req && b_req && pcf_q != 16'hFFFF) pcf_q <= pcf_q + 16'd1;
    end
  end

  assign perf_grants_a  = pga_q;
  assign perf_grants_b  = pgb_q;
  assign perf_conflicts = pcf_q;
`endif

endmodule

// File: tb/tb_sbox_sched.sv
// Scoreboard bench for sbox_sched at LANES=4 and LANES=1; expected results are
// queued when a request is raised and compared when the done pulse appears.
module tb_sbox_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_req4, b_req4, a_done4, b_done4, busy4;
  logic [127:0] a_data4, a_res4;
  logic [31:0]  b_data4, b_res4;
  logic         a_req1, b_req1, a_done1, b_done1, busy1;
  logic [127:0] a_data1, a_res1;
  logic [31:0]  b_data1, b_res1;
`ifdef SBOX_SCHED_PERF_EN
  logic [15:0]  pga4, pgb4, pcf4, pga1, pgb1, pcf1;
`endif

  sbox_sched #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst),
    .a_req(a_req4), .a_data(a_data4), .a_result(a_res4), .a_done(a_done4),
    .b_req(b_req4), .b_data(b_data4), .b_result(b_res4), .b_done(b_done4),
    .busy(busy4)
`ifdef SBOX_SCHED_PERF_EN
    , .perf_grants_a(pga4), .perf_grants_b(pgb4), .perf_conflicts(pcf4)
`endif
  );

  sbox_sched #(.LANES(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req1), .a_data(a_data1), .a_result(a_res1), .a_done(a_done1),
    .b_req(b_req1), .b_data(b_data1), .b_result(b_res1), .b_done(b_done1),
    .busy(busy1)
`ifdef SBOX_SCHED_PERF_EN
    , .perf_grants_a(pga1), .perf_grants_b(pgb1), .perf_conflicts(pcf1)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] q_a4 [$];
  logic [127:0] q_a1 [$];
  logic [31:0]  q_b4 [$];
  logic [31:0]  q_b1 [$];
  logic [7:0]   order4 [$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // Table generated by walking generator 3 and its inverse together.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_tab[d[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31 - 8*i -: 8] = sbox_tab[d[31 - 8*i -: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (a_done4) begin
      order4.push_back("A");
      if (q_a4.size() == 0) check_eq("a4_unexpected_done", 128'(a_done4), 128'(0));
      else check_eq("a4_result", a_res4, q_a4.pop_front());
      check_eq("a4_b4_done_exclusive", 128'(b_done4), 128'(0));
    end
    if (b_done4) begin
      order4.push_back("B");
      if (q_b4.size() == 0) check_eq("b4_unexpected_done", 128'(b_done4), 128'(0));
      else check_eq("b4_result", 128'(b_res4), 128'(q_b4.pop_front()));
    end
    if (a_done1) begin
      if (q_a1.size() == 0) check_eq("a1_unexpected_done", 128'(a_done1), 128'(0));
      else check_eq("a1_result", a_res1, q_a1.pop_front());
    end
    if (b_done1) begin
      if (q_b1.size() == 0) check_eq("b1_unexpected_done", 128'(b_done1), 128'(0));
      else check_eq("b1_result", 128'(b_res1), 128'(q_b1.pop_front()));
    end
  end

  // k: 0=A@LANES4, 1=B@LANES4, 2=A@LANES1, 3=B@LANES1
  function automatic logic get_done(input int k);
    case (k)
      0: return a_done4;
      1: return b_done4;
      2: return a_done1;
      default: return b_done1;
    endcase
  endfunction

  function automatic logic get_busy(input int k);
    return (k < 2) ? busy4 : busy1;
  endfunction

  task automatic set_req(input int k, input logic v);
    case (k)
      0: a_req4 = v;
      1: b_req4 = v;
      2: a_req1 = v;
      default: b_req1 = v;
    endcase
  endtask

  // lat > 0: expect done at the lat-th negedge after raising req (grant edge counted),
  // with busy high on every one of those samples.
  task automatic run_job(input int k, input logic [127:0] d, input logic [127:0] exp, input int lat);
    bit seen;
    int n, nbusy;
    seen = 0; n = 0; nbusy = 0;
    @(negedge clk);
    case (k)
      0: begin a_data4 = d;       q_a4.push_back(exp); end
      1: begin b_data4 = d[31:0]; q_b4.push_back(exp[31:0]); end
      2: begin a_data1 = d;       q_a1.push_back(exp); end
      default: begin b_data1 = d[31:0]; q_b1.push_back(exp[31:0]); end
    endcase
    set_req(k, 1'b1);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (get_busy(k)) nbusy++;
      if (get_done(k)) begin
        seen = 1;
        n = i;
        break;
      end
    end
    set_req(k, 1'b0);
    if (!seen) check_eq($sformatf("timeout_job%0d", k), 128'(get_done(k)), 128'(1));
    else if (lat > 0) begin
      check_eq($sformatf("latency_job%0d", k), 128'(n), 128'(lat));
      check_eq($sformatf("busy_cycles_job%0d", k), 128'(nbusy), 128'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    logic [127:0] ra [2];
    logic [31:0]  rb [2];
    build_sbox();
    rst = 1'b1;
    a_req4 = 0; b_req4 = 0; a_req1 = 0; b_req1 = 0;
    a_data4 = '0; b_data4 = '0; a_data1 = '0; b_data1 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_a_result", a_res4, 128'(0));
    check_eq("rst_b_result", 128'(b_res4), 128'(0));
    check_eq("rst_busy", 128'(busy4), 128'(0));
    check_eq("rst_done", 128'({a_done4, b_done4, a_done1, b_done1}), 128'(0));
    check_eq("rst_busy1", 128'(busy1), 128'(0));
    rst = 1'b0;

    // Known-answer SubBytes, then SubWord leaving a_result alone.
    run_job(0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 5);
    run_job(1, 128'h00000000_00000000_00000000_cf4f3c09, 128'h8a84eb01, 2);
    check_eq("a_result_held", a_res4, 128'h638293c31bfc33f5c4eeacea4bc12816);

    for (int i = 0; i < 3; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      run_job(0, r, sub_bytes(r), 5);
      r = 128'($urandom);
      run_job(1, r, 128'(sub_word(r[31:0])), 2);
    end

    // Simultaneous requests re-raised after each done: strict alternation.
    repeat (2) @(negedge clk);
    order4.delete();
    for (int i = 0; i < 2; i++) begin
      ra[i] = {$urandom, $urandom, $urandom, $urandom};
      rb[i] = $urandom;
    end
    fork
      begin
        run_job(0, ra[0], sub_bytes(ra[0]), 0);
        run_job(0, ra[1], sub_bytes(ra[1]), 0);
      end
      begin
        run_job(1, 128'(rb[0]), 128'(sub_word(rb[0])), 0);
        run_job(1, 128'(rb[1]), 128'(sub_word(rb[1])), 0);
      end
    join
    repeat (2) @(negedge clk);
    check_eq("order_count", 128'(order4.size()), 128'(4));
    if (order4.size() == 4) begin
      check_eq("order_0", 128'(order4[0]), 128'("A"));
      check_eq("order_1", 128'(order4[1]), 128'("B"));
      check_eq("order_2", 128'(order4[2]), 128'("A"));
      check_eq("order_3", 128'(order4[3]), 128'("B"));
    end

    // Reset during the third beat of an A job discards it.
    @(negedge clk);
    a_data4 = 128'hffeeddccbbaa99887766554433221100;
    a_req4 = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", 128'(busy4), 128'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_a_result", a_res4, 128'(0));
    check_eq("mid_rst_b_result", 128'(b_res4), 128'(0));
    check_eq("mid_rst_busy_done", 128'({busy4, a_done4, b_done4}), 128'(0));
    a_req4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("no_done_after_abort", 128'({a_done4, busy4}), 128'(0));
    r = 128'hffeeddccbbaa99887766554433221100;
    run_job(0, r, sub_bytes(r), 5);
`ifdef SBOX_SCHED_PERF_EN
    check_eq("perf_grants_a4", 128'(pga4), 128'(1));
    check_eq("perf_grants_b4", 128'(pgb4), 128'(0));
`endif

    // Single-lane instance.
    run_job(3, 128'h00535aff, 128'h63edbe16, 5);
`ifdef SBOX_SCHED_PERF_EN
    check_eq("perf_grants_b1", 128'(pgb1), 128'(1));
    check_eq("perf_conflicts1", 128'(pcf1), 128'(0));
`endif
    r = {$urandom, $urandom, $urandom, $urandom};
    run_job(2, r, sub_bytes(r), 17);
    check_eq("b1_result_held", 128'(b_res1), 128'h63edbe16);
    r = 128'($urandom);
    run_job(3, r, 128'(sub_word(r[31:0])), 5);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", 128'(q_a4.size() + q_b4.size() + q_a1.size() + q_b1.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Shares a small bank of byte S-box lanes between two requesters: A is the round datapath (SubBytes on the 128-bit state) and B is the key schedule (SubWord on a 32-bit word).
- Non-preemptive round-robin arbiter plus a beat sequencer that streams LANES bytes per cycle through combinational `sbox` instances.
- Results are returned in registered result buffers with a one-cycle done pulse.
- Sits between the round controller / key expansion and the S-box logic, replacing 20 dedicated S-boxes with LANES.

Parameters:
- LANES, 4, number of `sbox` instances used per cycle; legal values 1, 2, 4 (must divide 4 and 16).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  requester A wants SubBytes; hold high with a_data stable until a_done
- a_data  in  128  state input; byte i = a_data[127-8i -: 8]
- a_result  out  128  SubBytes result, held until next A grant completes
- a_done  out  1  one-cycle pulse, a_result valid
- b_req  in  1  requester B wants SubWord; same rules as A
- b_data  in  32  word input; byte i = b_data[31-8i -: 8]
- b_result  out  32  SubWord result, held
- b_done  out  1  one-cycle pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, last_served = B (so A wins the first tie), beat counter 0, work registers 0, a_result/b_result 0, a_done/b_done/busy 0.
- Reset is asynchronous and may assert mid-operation: the in-flight job is discarded, no done pulse is issued, and the requester must re-request.
- FSM states:
  - IDLE -> BUSY_A when a_req && (!b_req || last_served==B).
  - IDLE -> BUSY_B when b_req && (!a_req || last_served==A).
  - BUSY_x -> DONE_x at the last beat.
  - DONE_x -> IDLE.
- Grant edge E0 (IDLE sampling a request):
  - Captures a_data/b_data into the work register.
  - Sets beat = 0 and last_served = x.
- Beats: NB_A = 16/LANES, NB_B = 4/LANES.
  - At edges E1..E_NB, bytes beat*LANES .. beat*LANES+LANES-1 of the work register pass through the `sbox` lanes.
  - Results are written to the same byte positions of x_result; beat then increments.
- Done timing: x_done is high exactly during the DONE_x cycle, i.e. the cycle after edge E_NB.
  - A latency is NB_A+1 edges (5 at LANES=4); B latency is NB_B+1 edges (2 at LANES=4).
- x_result updates only at beat edges of an x job, and is otherwise stable.
- Requester protocol: deassert x_req at the edge that ends the done cycle. DONE_x is never a sampling state, so a stale request is never double-granted.
- Request dropped while BUSY_x: the job still completes and the done pulse is still issued.
- Both requests present in IDLE: strict alternation. Back-to-back A and B are served A, B, A, ...
- Request rising during BUSY: waits; it is sampled the first IDLE cycle after DONE.
- Beat counter width is clog2(16/LANES) bits (at least 1) and wraps to 0 on entering DONE.
- Lanes idle (not BUSY) drive sbox inputs with 0; outputs are ignored.

Optional Feature:
- SBOX_SCHED_PERF_EN defined: adds outputs perf_grants_a[15:0], perf_grants_b[15:0] and perf_conflicts[15:0].
  - Each counter is saturating at 16'hFFFF and reset to 0.
  - perf_grants_a / perf_grants_b increment on each grant edge for that requester.
  - perf_conflicts increments on each IDLE cycle where a_req && b_req.
- Undefined: these ports and counters do not exist; function and timing are otherwise identical.

Decomposition:
- Package sbox_sched_pkg holds:
  - State encoding localparams S_IDLE, S_BUSY_A, S_BUSY_B, S_DONE_A, S_DONE_B.
  - NBYTES_STATE=16 and NBYTES_WORD=4.
  - Requester id constants REQ_A=0, REQ_B=1.
- Instantiates LANES copies of the existing `sbox` module via generate.
- One natural sub-module: sbox_sched_arb (IDLE tie-break and last_served register); the beat datapath stays in the top.

Test Plan:
- Reset then a_req with a_data=00112233445566778899aabbccddeeff, LANES=4 -> a_done pulses 5 edges after grant; a_result=638293c31bfc33f5c4eeacea4bc12816; busy high for 5 cycles.
- b_req with b_data=cf4f3c09 -> b_done 2 edges after grant; b_result=8a84eb01; a_result unchanged.
- a_req and b_req raised in the same cycle after reset, each re-raised after its done -> grant order A, B, A, B; no cycle with both done high.
- Assert rst in the 3rd beat of an A job -> all outputs 0 immediately, no a_done; a re-request completes normally with the correct result.
- LANES=1, b_data=00535aff -> b_done 5 edges after grant; b_result=63edbe16; with SBOX_SCHED_PERF_EN, perf_grants_b=1 and perf_conflicts=0.
